bin2bcd_seq: RTL and testbench

- Parametrised, sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm.
- Performs one shift per clock.
- Uses valid/ready handshakes on both sides.
- Replaces the fixed 16-bit combinational converter wherever the area of a wide combinational BCD tree is not justified, e.g. for display and UART-print paths.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state encoding and width helper for the BCD converter
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit pre-shift adjust (+3 when digit >= 5)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] in_digit,
  output logic [BCD_DIGIT_W-1:0] out_digit
);

  assign out_digit = (in_digit >= ADJ_THRESH) ? in_digit + ADJ_ADD : in_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter, one shift per clock
// Define BIN2BCD_SIGNED_EN to treat in_bin as two's complement and report the sign on out_neg.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BIN_W-1:0]                in_bin,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   out_bcd,
  output logic                            out_ovf,
  output logic                            out_neg
);

  localparam int CNT_W = clog2(BIN_W + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic             r_ovf;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;

  logic [BCD_W-1:0] w_adj;
  logic [BIN_W-1:0] w_mag;
  logic             w_neg;
  logic             w_accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .in_digit  (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .out_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BIN2BCD_SIGNED_EN
  // The most negative input wraps to 2^(BIN_W-1), which still fits unsigned.
  assign w_neg = in_bin[BIN_W-1];
  assign w_mag = w_neg ? -in_bin : in_bin;
`else
  assign w_neg = 1'b0;
  assign w_mag = in_bin;
`endif

  assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_bin   <= w_mag;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_neg   <= w_neg;
      r_cnt   <= CNT_W'(BIN_W);
      r_state <= ST_CONV;
    end else begin
      case (r_state)
        ST_CONV: begin
          // A set bit leaving the top digit means the value no longer fits.
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_ovf <= r_ovf | w_adj[BCD_W-1];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign out_bcd   = r_bcd;
  assign out_ovf   = r_ovf;
  assign out_neg   = r_neg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq (5-digit and 4-digit instances in lockstep)
// Honours BIN2BCD_SIGNED_EN in its reference model.
module tb_bin2bcd_seq;

  localparam int BIN_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_bin;
  logic        out_ready;

  logic        in_ready5, out_valid5, ovf5, neg5;
  logic [19:0] bcd5;
  logic        in_ready4, out_valid4, ovf4, neg4;
  logic [15:0] bcd4;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .in_bin(in_bin),
    .out_valid(out_valid5), .out_ready(out_ready), .out_bcd(bcd5), .out_ovf(ovf5), .out_neg(neg5)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_bin(in_bin),
    .out_valid(out_valid4), .out_ready(out_ready), .out_bcd(bcd4), .out_ovf(ovf4), .out_neg(neg4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned mag;
    bit          neg;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model_bcd(input int unsigned m, input int d);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = m;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit model_ovf(input int unsigned m, input int d);
    int unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return m >= p;
  endfunction

  function automatic exp_t mk(input logic [15:0] v);
    exp_t e;
`ifdef BIN2BCD_SIGNED_EN
    e.neg = v[15];
    e.mag = v[15] ? (32'd65536 - {16'd0, v}) : {16'd0, v};
`else
    e.neg = 1'b0;
    e.mag = {16'd0, v};
`endif
    e.acc = cyc + 1;
    return e;
  endfunction

  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [19:0] prev_b = '0;

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid5, 1);
        chk("hold_bcd", bcd5, prev_b);
      end
      if (out_valid5 || out_valid4) begin
        chk("valid_lockstep", out_valid4, out_valid5);
        chk("in_ready_in_done", in_ready5, out_ready);
        if (!prev_v) begin
          if (sb.size() == 0) chk("spurious_valid", 1, 0);
          else chk("latency", cyc - sb[0].acc, BIN_W);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("bcd5", bcd5, model_bcd(e.mag, 5));
            chk("ovf5", ovf5, model_ovf(e.mag, 5));
            chk("neg5", neg5, e.neg);
            chk("bcd4", bcd4, model_bcd(e.mag, 4) & 20'hFFFF);
            chk("ovf4", ovf4, model_ovf(e.mag, 4));
            chk("neg4", neg4, e.neg);
            ok = 1'b1;
            for (int i = 0; i < 5; i++) if (bcd5[4*i +: 4] > 4'd9) ok = 1'b0;
            for (int i = 0; i < 4; i++) if (bcd4[4*i +: 4] > 4'd9) ok = 1'b0;
            chk("digits_le9", ok, 1);
          end
        end
      end
      prev_v = out_valid5;
      prev_r = out_ready;
      prev_b = bcd5;
    end
  end

  task automatic send(input logic [15:0] v);
    int budget;
    bit done;
    budget = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_bin = v;
    while (!done) begin
      @(negedge clk);
      if (in_ready5) begin
        sb.push_back(mk(v));
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 200) begin
          chk("accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bin = 16'($urandom);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || out_valid5) && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (b >= 500) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bin = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid5, 0);
    chk("reset_bcd5", bcd5, 0);
    chk("reset_bcd4", bcd4, 0);
    chk("reset_ovf", ovf5, 0);
    chk("reset_neg", neg5, 0);
    chk("reset_in_ready", in_ready5, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(16'd0);
    send(16'd65535);
    wait_drain();

    rdy_mode = 2;
    @(posedge clk);
    #2;
    send(16'd1234);
    fork
      send(16'd999);
    join_none
    b = 0;
    while (!out_valid5 && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (b >= 40) chk("bp_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bcd", bcd5, 20'h01234);
      chk("bp_valid", out_valid5, 1);
      chk("bp_in_ready", in_ready5, 0);
    end
    rdy_mode = 0;
    wait fork;
    wait_drain();

    send(16'd12345);
    send(16'd9999);
    wait_drain();

    send(16'd4321);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid5, 0);
    chk("abort_bcd5", bcd5, 0);
    chk("abort_bcd4", bcd4, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'd42);
    wait_drain();

    send(16'hFFFF);
    send(16'h8000);
    send(16'd32767);
    wait_drain();

    rdy_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      send(16'($urandom));
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
